// File: rtl/inv2_share_arb_pkg.sv
// Shared types and constants for the inv2_share_arb arbiter and its inv2_serial inverter.
// The optional singular-matrix pre-check is enabled by defining INV2_ARB_SING_EN.
package inv2_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    localparam int N_DEF    = 20;
    localparam int FRAC_DEF = 10;
    localparam int NREQ_DEF = 4;

    function automatic int idx_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    function automatic int one_of(input int frac);
        return 1 << frac;
    endfunction

    localparam int IDX_W = idx_w(NREQ_DEF);
    localparam int ONE   = one_of(FRAC_DEF);

endpackage

// File: rtl/inv2_share_arb_if.sv
// Requester-side bus of inv2_share_arb: packed per-requester operands in, shared result bus out.
interface inv2_share_arb_if #(
    parameter int N    = 20,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [NREQ*N-1:0] op_c;
    logic [NREQ*N-1:0] op_d;
    logic [NREQ-1:0]   ack;
    logic [N-1:0]      res_a;
    logic [N-1:0]      res_b;
    logic [N-1:0]      res_c;
    logic [N-1:0]      res_d;
    logic              err;
    logic              busy;

    modport master (
        output req, op_a, op_b, op_c, op_d,
        input  ack, res_a, res_b, res_c, res_d, err, busy
    );

    modport slave (
        input  req, op_a, op_b, op_c, op_d,
        output ack, res_a, res_b, res_c, res_d, err, busy
    );
endinterface

// File: rtl/inv2_share_arb_serial.sv
// inv2_serial: multi-cycle 2x2 fixed-point inverter. Computes 1/det by restoring division
// (2^(3*FRAC) / det), then scales the adjugate by it. One-cycle done pulse with results.
module inv2_serial #(
    parameter int N    = 20,
    parameter int FRAC = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    input  logic signed [N-1:0] i_c,
    input  logic signed [N-1:0] i_d,
    output logic                o_done,
    output logic signed [N-1:0] o_ia,
    output logic signed [N-1:0] o_ib,
    output logic signed [N-1:0] o_ic,
    output logic signed [N-1:0] o_id
);
    localparam int DW = 2*N + 1;
    localparam int QW = 3*FRAC + 1;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {S_IDLE, S_DET, S_DIV, S_MUL} ser_state_t;

    ser_state_t          r_state;
    logic signed [N-1:0] r_a, r_b, r_c, r_d;
    logic                r_neg;
    logic [DW-1:0]       r_den;
    logic [DW-1:0]       r_rem;
    logic [QW-1:0]       r_q;
    logic [CW-1:0]       r_cnt;

    logic signed [DW-1:0] w_det;
    logic [DW:0]          w_shift;
    logic                 w_ge;

    assign w_det   = DW'(r_a) * DW'(r_d) - DW'(r_b) * DW'(r_c);
    // Dividend is a single 1 at bit 3*FRAC, shifted in on the first step only.
    assign w_shift = {r_rem, (r_cnt == CW'(QW-1))};
    assign w_ge    = (w_shift >= {1'b0, r_den});

    function automatic logic signed [N-1:0] scale(input logic signed [N-1:0] x,
                                                  input logic neg,
                                                  input logic [QW-1:0] q);
        logic signed [N+QW:0] p;
        p = (N+QW+1)'(x) * $signed({1'b0, q});
        if (neg) p = -p;
        p = p >>> FRAC;
        return p[N-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_neg   <= 1'b0;
            r_den   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            o_done  <= 1'b0;
            o_ia    <= '0;
            o_ib    <= '0;
            o_ic    <= '0;
            o_id    <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_c     <= i_c;
                        r_d     <= i_d;
                        r_state <= S_DET;
                    end
                end
                S_DET: begin
                    r_neg   <= w_det[DW-1];
                    r_den   <= w_det[DW-1] ? DW'(-w_det) : DW'(w_det);
                    r_rem   <= '0;
                    r_q     <= '0;
                    r_cnt   <= CW'(QW-1);
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_ge ? DW'(w_shift - {1'b0, r_den}) : DW'(w_shift);
                    r_q   <= {r_q[QW-2:0], w_ge};
                    if (r_cnt == '0) r_state <= S_MUL;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_MUL: begin
                    o_ia    <= scale(r_d, r_neg, r_q);
                    o_ib    <= scale(r_b, ~r_neg, r_q);
                    o_ic    <= scale(r_c, ~r_neg, r_q);
                    o_id    <= scale(r_a, r_neg, r_q);
                    o_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/inv2_share_arb.sv
// Round-robin arbiter sharing one inv2_serial inverter between NREQ requesters.
// Define INV2_ARB_SING_EN to add a determinant pre-check that answers singular inputs directly.
module inv2_share_arb
    import inv2_arb_pkg::*;
#(
    parameter int N    = 20,
    parameter int FRAC = 10,
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    inv2_share_arb_if.slave bus
);
    localparam int IW = idx_w(NREQ);

    arb_state_t          r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_idx;
    logic                r_mask;
    logic signed [N-1:0] r_a, r_b, r_c, r_d;
    logic                r_start;
    logic [NREQ-1:0]     r_ack;
    logic [N-1:0]        r_res_a, r_res_b, r_res_c, r_res_d;

    logic [NREQ-1:0]     w_req_eff;
    logic [IW-1:0]       w_win;
    logic                w_found;
    logic                w_rst_n;
    logic                w_done;
    logic signed [N-1:0] w_ia, w_ib, w_ic, w_id;

`ifdef INV2_ARB_SING_EN
    logic                  r_err;
    logic signed [2*N:0]   w_det;
    assign w_det   = (2*N+1)'(r_a) * (2*N+1)'(r_d) - (2*N+1)'(r_b) * (2*N+1)'(r_c);
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    // Last winner is masked for one IDLE cycle so a late req drop is never re-served.
    always_comb begin
        w_req_eff = bus.req;
        if (r_mask) w_req_eff[r_idx] = 1'b0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_eff[(32'(r_ptr) + 1 + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IW'((32'(r_ptr) + 1 + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= IW'(NREQ-1);
            r_idx   <= '0;
            r_mask  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_start <= 1'b0;
            r_ack   <= '0;
            r_res_a <= '0;
            r_res_b <= '0;
            r_res_c <= '0;
            r_res_d <= '0;
`ifdef INV2_ARB_SING_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mask <= 1'b0;
                    if (w_found) begin
                        r_idx <= w_win;
                        r_ptr <= w_win;
                        r_a   <= bus.op_a[32'(w_win)*N +: N];
                        r_b   <= bus.op_b[32'(w_win)*N +: N];
                        r_c   <= bus.op_c[32'(w_win)*N +: N];
                        r_d   <= bus.op_d[32'(w_win)*N +: N];
`ifdef INV2_ARB_SING_EN
                        r_state <= ST_CHECK;
`else
                        r_start <= 1'b1;
                        r_state <= ST_LAUNCH;
`endif
                    end
                end
`ifdef INV2_ARB_SING_EN
                ST_CHECK: begin
                    if (w_det == '0) begin
                        r_res_a <= '0;
                        r_res_b <= '0;
                        r_res_c <= '0;
                        r_res_d <= '0;
                        r_err   <= 1'b1;
                        r_ack   <= NREQ'(1) << r_idx;
                        r_state <= ST_RESP;
                    end else begin
                        r_err   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= ST_LAUNCH;
                    end
                end
`endif
                ST_LAUNCH: begin
                    r_start <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_res_a <= w_ia;
                        r_res_b <= w_ib;
                        r_res_c <= w_ic;
                        r_res_d <= w_id;
`ifdef INV2_ARB_SING_EN
                        r_err   <= 1'b0;
`endif
                        r_ack   <= NREQ'(1) << r_idx;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ack   <= '0;
                    r_mask  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rst_n   = ~rst;
    assign bus.ack   = r_ack;
    assign bus.res_a = r_res_a;
    assign bus.res_b = r_res_b;
    assign bus.res_c = r_res_c;
    assign bus.res_d = r_res_d;
    assign bus.busy  = (r_state != ST_IDLE);

    inv2_serial #(
        .N    (N),
        .FRAC (FRAC)
    ) u_inv (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .i_start (r_start),
        .i_a     (r_a),
        .i_b     (r_b),
        .i_c     (r_c),
        .i_d     (r_d),
        .o_done  (w_done),
        .o_ia    (w_ia),
        .o_ib    (w_ib),
        .o_ic    (w_ic),
        .o_id    (w_id)
    );
endmodule

// File: tb/tb_inv2_share_arb.sv
// Directed bench for inv2_share_arb; expectations adapt to INV2_ARB_SING_EN for the singular case.
`timescale 1ns/1ps
module tb_inv2_share_arb;
    import inv2_arb_pkg::*;

    localparam int N    = 20;
    localparam int FRAC = 10;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv2_share_arb_if #(.N(N), .NREQ(NREQ)) bus();

    inv2_share_arb #(.N(N), .FRAC(FRAC), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         idx;
        logic [N-1:0] a, b, c, d;
        logic       err;
        int         cyc;
        int         dcyc;
    } ack_t;

    ack_t log_q[$];
    int   gaps[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, last_done = -100, start_cnt = 0, bad_ack = 0, idle_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ack_t e;
        if (dut.w_done) last_done = cyc;
        if (dut.r_start) start_cnt++;
        if (!bus.busy) idle_run++;
        else begin
            if (idle_run > 0) gaps.push_back(idle_run);
            idle_run = 0;
        end
        if (bus.ack != '0) begin
            if (!$onehot(bus.ack)) bad_ack++;
            e.idx = -1;
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) e.idx = i;
            e.a = bus.res_a; e.b = bus.res_b; e.c = bus.res_c; e.d = bus.res_d;
            e.err = bus.err; e.cyc = cyc; e.dcyc = last_done;
            log_q.push_back(e);
        end
    end

    function automatic logic [N-1:0] fx(input int v);
        return v[N-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        bus.op_a[i*N +: N] = fx(a);
        bus.op_b[i*N +: N] = fx(b);
        bus.op_c[i*N +: N] = fx(c);
        bus.op_d[i*N +: N] = fx(d);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ack"}, bus.ack, '0);
        chk({tag, "_res_a"}, bus.res_a, '0);
        chk({tag, "_res_d"}, bus.res_d, '0);
        chk({tag, "_err"}, bus.err, 1'b0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_outs_zero(tag);
    endtask

    // Waits for n acks; drops acked reqs in drop_en either at the ack or one cycle later.
    task automatic service(input string tag, input int n, input logic [NREQ-1:0] drop_en,
                           input bit late, input int budget);
        int got = 0;
        int t = 0;
        logic [NREQ-1:0] pend = '0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            bus.req = bus.req & ~pend;
            pend = '0;
            if (bus.ack != '0) begin
                got++;
                if (late) pend = bus.ack & drop_en;
                else      bus.req = bus.req & ~(bus.ack & drop_en);
            end
        end
        if (pend != '0) begin
            @(negedge clk);
            bus.req = bus.req & ~pend;
        end
        #1;
        chk({tag, "_acks"}, got, n);
    endtask

    task automatic wait_state(input string tag, input arb_state_t s, input int budget);
        int t = 0;
        while (dut.r_state != s && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_state"}, dut.r_state == s, 1'b1);
    endtask

    task automatic chk_ack(input int k, input string tag, input int idx,
                           input int a, input int b, input int c, input int d,
                           input logic err, input bit lat);
        chk({tag, "_present"}, log_q.size() > k, 1'b1);
        if (log_q.size() > k) begin
            chk({tag, "_idx"}, log_q[k].idx, idx);
            chk({tag, "_a"}, log_q[k].a, fx(a));
            chk({tag, "_b"}, log_q[k].b, fx(b));
            chk({tag, "_c"}, log_q[k].c, fx(c));
            chk({tag, "_d"}, log_q[k].d, fx(d));
            chk({tag, "_err"}, log_q[k].err, err);
            if (lat) chk({tag, "_lat"}, log_q[k].cyc - log_q[k].dcyc, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int diag[4] = '{1024, 2048, 4096, 512};
        int inv[4]  = '{1024, 512, 256, 2048};
        int base;
        int s0;

        bus.req = '0;
        bus.op_a = '0; bus.op_b = '0; bus.op_c = '0; bus.op_d = '0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        rst = 1'b0;

        // Single request, late drop must not be re-served
        set_ops(0, 2048, 0, 0, 4096);
        bus.req[0] = 1'b1;
        service("t1", 1, 4'b0001, 1'b1, 300);
        chk_ack(0, "t1", 0, 512, 0, 0, 256, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        chk("t1_noreserve", log_q.size(), 1);

        // Two simultaneous requests
        do_reset("t2_rst");
        set_ops(0, 1024, 0, 0, 1024);
        set_ops(2, 4096, 0, 0, 4096);
        bus.req = 4'b0101;
        service("t2", 2, 4'b0101, 1'b0, 400);
        chk_ack(1, "t2a", 0, 1024, 0, 0, 1024, 1'b0, 1'b1);
        chk_ack(2, "t2b", 2, 256, 0, 0, 256, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        chk("t2_count", log_q.size(), 3);

        // All requests held: strict rotation, one idle cycle between transactions
        do_reset("t3_rst");
        for (int i = 0; i < NREQ; i++) set_ops(i, diag[i], 0, 0, diag[i]);
        base = log_q.size();
        bus.req = '1;
        service("t3_first", 1, '0, 1'b0, 300);
        gaps.delete();
        service("t3_rest", 7, '0, 1'b0, 2000);
        bus.req = '0;
        for (int k = 0; k < 8; k++)
            chk_ack(base + k, $sformatf("t3_%0d", k), k % 4, inv[k % 4], 0, 0, inv[k % 4], 1'b0, 1'b0);
        chk("t3_gaps", gaps.size(), 7);
        foreach (gaps[g]) chk($sformatf("t3_gap%0d", g), gaps[g], 1);

        // Reset during WAIT aborts; a following request completes
        set_ops(1, 1024, 1024, 0, 2048);
        bus.req = 4'b0010;
        wait_state("t4", ST_WAIT, 200);
        repeat (5) @(negedge clk);
        base = log_q.size();
        rst = 1'b1;
        bus.req[1] = 1'b0;
        @(negedge clk) rst = 1'b0;
        chk_outs_zero("t4_rst");
        repeat (80) @(negedge clk);
        chk("t4_noack", log_q.size(), base);
        bus.req[1] = 1'b1;
        service("t4", 1, 4'b0010, 1'b0, 300);
        chk_ack(base, "t4", 1, 1024, -512, 0, 512, 1'b0, 1'b1);

        // Operands changed during WAIT do not affect the result
        base = log_q.size();
        set_ops(1, -2048, 0, 0, 4096);
        bus.req[1] = 1'b1;
        wait_state("t5", ST_WAIT, 200);
        set_ops(1, 1024, 0, 0, 1024);
        service("t5", 1, 4'b0010, 1'b0, 300);
        chk_ack(base, "t5", 1, -512, 0, 0, 256, 1'b0, 1'b1);

        // Singular matrix
        base = log_q.size();
        s0 = start_cnt;
        set_ops(2, 1024, 2048, 2048, 4096);
        bus.req[2] = 1'b1;
        service("t6", 1, 4'b0100, 1'b0, 300);
`ifdef INV2_ARB_SING_EN
        chk_ack(base, "t6", 2, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("t6_start", start_cnt - s0, 0);
`else
        chk("t6_present", log_q.size() > base, 1'b1);
        if (log_q.size() > base) chk("t6_err", log_q[base].err, 1'b0);
        chk("t6_start", start_cnt - s0, 1);
`endif

        repeat (20) @(negedge clk);
        chk("bad_ack", bad_ack, 0);
        chk("total_acks", log_q.size(), 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
